serial_adder_ctrl: RTL and testbench

Bit-serial adder controller. It reuses one existing full_adder cell over WIDTH clock cycles to add two WIDTH-bit operands, LSB first, with a registered carry. A start/busy/done handshake sequences each operation. It sits between a requesting register bank and the single shared full_adder instance, trading area for latency.

---
 rtl/serial_adder_ctrl_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: default width and state encodings.
package serial_adder_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial adder controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder reused over WIDTH cycles, LSB first, start/busy/done handshake.
// Optional two's-complement overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   a_sh, b_sh, s_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               load_c, step_c, last_c;
  logic               s_fa, cout_fa;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (s_fa),
    .cout (cout_fa)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nx = state;
    load_c   = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_c   = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        step_c = 1'b1;
        if (cnt == CNT_LAST) begin
          last_c   = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load_c   = 1'b1;
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand shifters, carry, counter and result registers; busy/done track the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      busy <= (state_nx == ST_RUN);
      done <= (state_nx == ST_DONE);
      if (load_c) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (step_c) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        s_sh  <= {s_fa, s_sh[WIDTH-1:1]};
        carry <= cout_fa;
        cnt   <= cnt + CNT_W'(1);
      end
      if (last_c) begin
        sum  <= {s_fa, s_sh[WIDTH-1:1]};
        cout <= cout_fa;
`ifdef SERIAL_ADDER_OVF_EN
        // carry still holds the carry into the MSB on the last-bit edge
        ovf  <= carry ^ cout_fa;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: directed WIDTH=8 cases plus a WIDTH=4 exhaustive sweep.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } exp8_t;

  typedef struct packed {
    logic [3:0] s;
    logic       co;
    logic       ov;
  } exp4_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic       start4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf, ovf4;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  exp8_t q8[$];
  exp4_t q4[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    exp8_t e;
    t = {1'b0, x} + {1'b0, y} + 9'(c);
    e.s  = t[7:0];
    e.co = t[8];
    e.ov = (x[7] == y[7]) && (t[7] != x[7]);
    return e;
  endfunction

  function automatic exp4_t model4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] t;
    exp4_t e;
    t = {1'b0, x} + {1'b0, y} + 5'(c);
    e.s  = t[3:0];
    e.co = t[4];
    e.ov = (x[3] == y[3]) && (t[3] != x[3]);
    return e;
  endfunction

  // Result monitors: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      check("pending8", 64'(q8.size() != 0), 64'd1);
      if (q8.size() != 0) begin
        exp8_t e;
        e = q8.pop_front();
        check("sum8", 64'(sum), 64'(e.s));
        check("cout8", 64'(cout), 64'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf8", 64'(ovf), 64'(e.ov));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done4) begin
      check("pending4", 64'(q4.size() != 0), 64'd1);
      if (q4.size() != 0) begin
        exp4_t e;
        e = q4.pop_front();
        check("sum4", 64'({cout4, sum4}), 64'({e.co, e.s}));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf4", 64'(ovf4), 64'(e.ov));
`endif
      end
    end
  end

  task automatic wait_done8();
    for (int i = 0; i < 16 && !done; i++) @(negedge clk);
    check("done8_timeout", 64'(done), 64'd1);
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    q8.push_back(model8(x, y, c));
    @(negedge clk);
    start = 1'b0;
    wait_done8();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles, dc0;
    logic [7:0] held;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_state", 64'(dut.state), 64'(ST_IDLE));

    // 0+0 with busy-duration measurement
    @(negedge clk);
    a = 8'h00; b = 8'h00; cin = 1'b0; start = 1'b1;
    q8.push_back(model8(8'h00, 8'h00, 1'b0));
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(busy_cycles), 64'd8);
    check("done_after_busy", 64'(done), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);

    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'h10, 8'h20, 1'b0);

    // start during RUN is ignored; sum held meanwhile
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    q8.push_back(model8(8'h12, 8'h34, 1'b0));
    dc0 = done_cnt;
    held = sum;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sum_held_in_run", 64'(sum), 64'(held));
    wait_done8();
    repeat (12) @(negedge clk);
    check("ignored_start_dones", 64'(done_cnt - dc0), 64'd1);

    // reset in RUN cycle 4 aborts with no done
    @(negedge clk);
    a = 8'h55; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dc0 = done_cnt;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    check("abort_state", 64'(dut.state), 64'(ST_IDLE));
    repeat (12) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dc0), 64'd0);
    run_op(8'h01, 8'h02, 1'b0);

    // back-to-back: start held through DONE with new operands
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    q8.push_back(model8(8'h12, 8'h34, 1'b0));
    @(negedge clk);
    wait_done8();
    a = 8'h0F; b = 8'h01; cin = 1'b0;
    q8.push_back(model8(8'h0F, 8'h01, 1'b0));
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done8();
    repeat (3) @(negedge clk);

    // exhaustive WIDTH=4 sweep
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); start4 = 1'b1;
          q4.push_back(model4(4'(x), 4'(y), 1'(c)));
          @(negedge clk);
          start4 = 1'b0;
          for (int i = 0; i < 10 && !done4; i++) @(negedge clk);
          check("done4_timeout", 64'(done4), 64'd1);
        end
      end
    end
    repeat (3) @(negedge clk);
    check("q8_drained", 64'(q8.size()), 64'd0);
    check("q4_drained", 64'(q4.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
